// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encodings, opcode constants and small helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Counter width that stays legal when there is only a single chunk.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-wide ripple of full-adder cells; also exports the carry into the MSB for overflow.
module adder_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] out,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .out   (out[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// 1-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic out,
  output logic c_out
);

  assign out   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, carry registered
// between chunks, valid/ready handshakes on both sides.
module serial_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned CntW       = cnt_width(NUM_CHUNKS);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_CHUNKS - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              carry_q, carry_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_sum;
  logic              chunk_co, chunk_cmsb;

  // Select the operand chunk addressed by the counter.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (cnt_q == CntW'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (chunk_a),
    .b     (chunk_b),
    .c_in  (carry_q),
    .out   (chunk_sum),
    .c_out (chunk_co),
    .c_msb (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract as a + ~b + 1; c_in plays no part in sub mode.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = (sub == SUB) ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        carry_d = chunk_co;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
          if (cnt_q == CntW'(i)) begin
            out_d[i*CHUNK +: CHUNK] = chunk_sum;
          end
        end
        if (cnt_q == LastCnt) begin
          c_out_d = chunk_co;
          ovf_d   = chunk_cmsb ^ chunk_co;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule
